set_assoc_cache: RTL
====================

// Module: set_assoc_cache
// PURPOSE
//  Parametrised N-way set-associative cache between the core load/store path and a block-wide memory port.
//  Selectable write-back or write-through, write-allocate, true-LRU replacement. Hit latency 2 cycles;
//  misses fetch one block over a valid/waitrequest memory bus.
// PARAMETERS
//  WORD         32  data word width in bits (multiple of 8)
//  ADDR_WIDTH   20  word address width
//  NUM_SETS     64  sets (power of 2, >=2)
//  ASSOC        2   ways per set (power of 2, >=2)
//  BLOCK_WORDS  4   words per block (power of 2, >=2)
//  WRITE_BACK   1   1 = write-back + dirty bits; 0 = write-through
// PORTS
//  clk                 in   1                 clock, all logic on rising edge
//  rst                 in   1                 synchronous, active-low reset
//  i_p_addr            in   ADDR_WIDTH        processor word address
//  i_p_byte_en         in   WORD/8            write byte enables
//  i_p_writedata       in   WORD              write data
//  i_p_read/i_p_write  in   1 each            request strobes
//  o_p_readdata        out  WORD              read data
//  o_p_readdata_valid  out  1                 one-cycle pulse with read data
//  o_p_waitrequest     out  1                 high = request not accepted
//  o_m_addr            out  ADDR_WIDTH        block-aligned memory address (offset bits 0)
//  o_m_writedata       out  WORD*BLOCK_WORDS  block write data, word0 in LSBs
//  o_m_read/o_m_write  out  1 each            memory request strobes
//  i_m_readdata        in   WORD*BLOCK_WORDS  refill block
//  i_m_readdata_valid  in   1                 refill data valid
//  i_m_waitrequest     in   1                 high = memory request stalled
// BEHAVIOUR
//  Address split: OFF=log2(BLOCK_WORDS) LSBs, IDX=log2(NUM_SETS) next, TAG = remaining MSBs.
//  Reset (rst==0 at edge): state IDLE; all valid/dirty cleared; LRU age of way w = w; every output 0
//   (o_p_waitrequest 0). Data/tag arrays not cleared. Reset mid-transaction aborts it: o_m_read/o_m_write
//   low next cycle; pending refill discarded.
//  o_p_waitrequest = (state != IDLE), combinational from state.
//  Accept: in IDLE with read|write high at edge -> latch addr/byte_en/data/op, go COMP. Read+write both
//   high: treated as write. Inputs ignored outside IDLE.
//  FSM: IDLE, COMP, WB, FETCH, FETCH_WAIT, WT.
//  COMP: tag compare all ways of set IDX (hit = valid & tag match; at most one way matches).
//   Read hit: o_p_readdata <= word OFF of hit way, o_p_readdata_valid pulses 1 cycle -> IDLE.
//   Write hit: merge bytes with byte_en into word OFF; WRITE_BACK=1: set dirty -> IDLE;
//    WRITE_BACK=0 -> WT. byte_en==0 still counts as a write.
//   Hit updates LRU: hit way age 0; ways with age < old age +1; others unchanged.
//   Miss: victim = lowest-index invalid way, else way with age ASSOC-1. If WRITE_BACK & victim valid &
//    dirty -> WB, else -> FETCH. Victim index held until refill.
//  WB: o_m_write=1, o_m_addr={victim tag,IDX,0}, o_m_writedata=victim block; held stable until edge with
//   i_m_waitrequest=0 -> FETCH.
//  FETCH: o_m_read=1, o_m_addr={TAG,IDX,0}, stable until edge with i_m_waitrequest=0 -> FETCH_WAIT.
//  FETCH_WAIT: on i_m_readdata_valid write block+tag into victim, valid=1, dirty=0 -> COMP (replays,
//   now hits; LRU updated there). i_m_readdata_valid in any other state ignored.
//  WT: o_m_write=1 with whole updated block at {TAG,IDX,0} until accepted -> IDLE.
//  Timing: accept edge N, COMP cycle N+1, hit data/valid cycle N+2, IDLE (next accept) at N+2.
//  At most one memory request outstanding; o_m_read and o_m_write never both high.
// TESTING  (NUM_SETS=4, ASSOC=2, BLOCK_WORDS=4; addr 0x10=tag1/idx0, 0x20=tag2, 0x30=tag3)
//  Cold read 0x10, memory returns {D,C,B,A} -> one o_m_read addr 0x10, readdata A; read 0x11 -> B,
//   valid 2 cycles after accept, no o_m_read.
//  Read 0x10,0x20,0x10,0x30 -> 0x30 evicts tag2; then 0x10 hits, 0x20 misses (o_m_read 0x20).
//  WRITE_BACK=1: word 0x11223344 at 0x10, write 0xAABBCCDD byte_en 0011 -> no o_m_write; read -> 0x1122CCDD;
//   evict via 0x20,0x30 -> o_m_write 0x10 word0=0x1122CCDD precedes o_m_read 0x30.
//  WRITE_BACK=0: write hit 0x10 -> o_m_write addr 0x10 with merged block; waitrequest high until accepted.
//  i_m_waitrequest high 5 cycles in FETCH -> o_m_read/o_m_addr stable all 5; then refill completes.
//  rst=0 during FETCH_WAIT -> next cycle all outputs 0; late i_m_readdata_valid ignored; re-read 0x10 misses.

Source files
------------

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//   N-way set-associative cache sitting between the core load/store path and a
//   block-wide memory port. Write-allocate, true-LRU replacement, write-back
//   (with dirty bits) or write-through selected by WRITE_BACK.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   i_p_addr/byte_en/...     processor request (word address, byte enables,
//                            write data, read/write strobes)
//   o_p_readdata(_valid)     read data with a one-cycle valid pulse
//   o_p_waitrequest          high whenever the controller is not idle
//   o_m_addr/writedata       block-aligned memory address and block write data
//   o_m_read/o_m_write       memory request strobes (never both high)
//   i_m_readdata(_valid)     refill block and its valid strobe
//   i_m_waitrequest          memory stall; a request is taken on an edge where it is low
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | ready, accepts a new processor request
// COMP       | tag compare on the latched address, hit service / miss decision
// WB         | writing the dirty victim block back to memory
// FETCH      | issuing the block read for the missing address
// FETCH_WAIT | waiting for refill data, then replays COMP
// WT         | write-through of the updated block after a write hit

module set_assoc_cache #(
  parameter int WORD        = 32,
  parameter int ADDR_WIDTH  = 20,
  parameter int NUM_SETS    = 64,
  parameter int ASSOC       = 2,
  parameter int BLOCK_WORDS = 4,
  parameter int WRITE_BACK  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         i_p_addr,
  input  logic [WORD/8-1:0]             i_p_byte_en,
  input  logic [WORD-1:0]               i_p_writedata,
  input  logic                          i_p_read,
  input  logic                          i_p_write,
  output logic [WORD-1:0]               o_p_readdata,
  output logic                          o_p_readdata_valid,
  output logic                          o_p_waitrequest,
  output logic [ADDR_WIDTH-1:0]         o_m_addr,
  output logic [WORD*BLOCK_WORDS-1:0]   o_m_writedata,
  output logic                          o_m_read,
  output logic                          o_m_write,
  input  logic [WORD*BLOCK_WORDS-1:0]   i_m_readdata,
  input  logic                          i_m_readdata_valid,
  input  logic                          i_m_waitrequest
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(ASSOC);
  localparam int BE_W  = WORD / 8;
  localparam int BLK_W = WORD * BLOCK_WORDS;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COMP       = 3'd1;
  localparam logic [2:0] ST_WB         = 3'd2;
  localparam logic [2:0] ST_FETCH      = 3'd3;
  localparam logic [2:0] ST_FETCH_WAIT = 3'd4;
  localparam logic [2:0] ST_WT         = 3'd5;

  // control registers
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [WORD-1:0]       wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [WORD-1:0]       rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  // storage: data/tag are plain memories (never reset), status bits are reset
  logic [BLK_W-1:0] data_q [NUM_SETS][ASSOC];
  logic [TAG_W-1:0] tag_q  [NUM_SETS][ASSOC];
  logic [NUM_SETS-1:0][ASSOC-1:0]            valid_q;
  logic [NUM_SETS-1:0][ASSOC-1:0]            dirty_q;
  logic [NUM_SETS-1:0][ASSOC-1:0][WAY_W-1:0] age_q;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign off = addr_q[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

  // tag compare
  logic [ASSOC-1:0] hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [BLK_W-1:0] hit_blk;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit     = |hit_vec;
  assign hit_blk = data_q[idx][hit_way];

  // victim: lowest invalid way first, otherwise the oldest way
  logic [WAY_W-1:0] victim;
  logic             found_inv;

  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (age_q[idx][w] == WAY_W'(ASSOC - 1)) victim = WAY_W'(w);
      end
    end
  end

  // word select and byte merge on the hit block
  logic [WORD-1:0]  rd_word;
  logic [BLK_W-1:0] merged;

  always_comb begin
    rd_word = '0;
    merged  = hit_blk;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (off == OFF_W'(k)) begin
        rd_word = hit_blk[k*WORD +: WORD];
        for (int b = 0; b < BE_W; b++) begin
          if (be_q[b]) merged[k*WORD + b*8 +: 8] = wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // next-state / datapath control
  logic             blk_we;
  logic [WAY_W-1:0] blk_way;
  logic [BLK_W-1:0] blk_wdata;
  logic             refill;
  logic             mark_dirty;
  logic             lru_upd;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    way_d      = way_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    blk_we     = 1'b0;
    blk_way    = hit_way;
    blk_wdata  = merged;
    refill     = 1'b0;
    mark_dirty = 1'b0;
    lru_upd    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_p_read || i_p_write) begin
          addr_d  = i_p_addr;
          be_d    = i_p_byte_en;
          wdata_d = i_p_writedata;
          is_wr_d = i_p_write;     // read+write together is a write
          state_d = ST_COMP;
        end
      end
      ST_COMP: begin
        if (hit) begin
          lru_upd = 1'b1;
          way_d   = hit_way;       // WT streams this way's block out
          if (!is_wr_q) begin
            rdata_d  = rd_word;
            rvalid_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            blk_we = 1'b1;
            if (WRITE_BACK != 0) begin
              mark_dirty = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_WT;
            end
          end
        end else begin
          way_d = victim;
          if ((WRITE_BACK != 0) && valid_q[idx][victim] && dirty_q[idx][victim]) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        if (!i_m_waitrequest) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!i_m_waitrequest) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (i_m_readdata_valid) begin
          blk_we    = 1'b1;
          blk_way   = way_q;
          blk_wdata = i_m_readdata;
          refill    = 1'b1;
          state_d   = ST_COMP;     // replay: hits now and updates LRU there
        end
      end
      ST_WT: begin
        if (!i_m_waitrequest) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      way_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      way_q    <= way_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // a refill arriving in the reset cycle must not land in the arrays
  always_ff @(posedge clk) begin
    if (rst && blk_we) begin
      data_q[idx][blk_way] <= blk_wdata;
      if (refill) tag_q[idx][blk_way] <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < ASSOC; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (refill) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= 1'b0;
      end
      if (mark_dirty) dirty_q[idx][hit_way] <= 1'b1;
      if (lru_upd) begin
        for (int w = 0; w < ASSOC; w++) begin
          if (WAY_W'(w) == hit_way) begin
            age_q[idx][w] <= '0;
          end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
            age_q[idx][w] <= age_q[idx][w] + 1'b1;
          end
        end
      end
    end
  end

  // outputs: all memory-side values are decoded from registered state,
  // so they stay stable for as long as a request is stalled
  assign o_p_waitrequest    = (state_q != ST_IDLE);
  assign o_p_readdata       = rdata_q;
  assign o_p_readdata_valid = rvalid_q;

  always_comb begin
    o_m_read      = (state_q == ST_FETCH);
    o_m_write     = (state_q == ST_WB) || (state_q == ST_WT);
    o_m_addr      = '0;
    o_m_writedata = '0;
    case (state_q)
      ST_WB: begin
        o_m_addr      = {tag_q[idx][way_q], idx, {OFF_W{1'b0}}};
        o_m_writedata = data_q[idx][way_q];
      end
      ST_FETCH: begin
        o_m_addr = {tag, idx, {OFF_W{1'b0}}};
      end
      ST_WT: begin
        o_m_addr      = {tag, idx, {OFF_W{1'b0}}};
        o_m_writedata = data_q[idx][way_q];
      end
      default: begin
        o_m_addr      = '0;
        o_m_writedata = '0;
      end
    endcase
  end

endmodule
